seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: XLEN, default 32, datapath width in bits; legal values 8..64, multiples of 8.
REQ-002 Parameter: CNT_W, default $clog2(XLEN)+1, iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous abort of any in-flight operation.
REQ-006 in_valid  input  1  operands and opcode are valid.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 a_in  input  XLEN  operand A.
REQ-009 b_in  input  XLEN  operand B.
REQ-010 alu_op  input  5  opcode: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLT, 00110 SLL, 00111 SRL, 01000 SRA, 01001 SLTU, 01010 MUL, 01011 MULHU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
REQ-011 out_valid  output  1  result and flags are valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  XLEN  registered result.
REQ-014 flag_z, flag_n, flag_c, flag_v  output  1 each  registered flags.
REQ-015 op_err  output  1  registered; high with a result for an undefined opcode (10000..11111).

Function
REQ-016 Accept occurs on a rising edge with in_valid && in_ready; in_ready SHALL equal (state == IDLE) && !flush.
REQ-017 FSM states SHALL be IDLE, BUSY, DONE.
REQ-018 IDLE: on accept of opcodes 00000..01001 or an undefined opcode, the block SHALL go to DONE with the result registered; out_valid is high on the next cycle (latency 1).
REQ-019 IDLE: on accept of 01010..01111, the block SHALL load the working registers, clear the counter, and go to BUSY.
REQ-020 BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes); after exactly XLEN steps the block SHALL go to DONE, giving out_valid XLEN+1 cycles after accept.
REQ-021 DIV/DIVU/REM/REMU with b_in == 0 SHALL skip BUSY (latency 1): quotient = all ones, remainder = a_in.
REQ-022 DIV/REM with a_in = most-negative and b_in = all ones SHALL skip BUSY (latency 1): quotient = a_in, remainder = 0.
REQ-023 Signed DIV/REM: quotient is negated if the operand signs differ; remainder takes the sign of a_in; truncation is toward zero.
REQ-024 MUL SHALL return the low XLEN bits and MULHU the high XLEN bits of the unsigned 2*XLEN product.
REQ-025 Shift amounts SHALL use b_in[$clog2(XLEN)-1:0]; SRA is arithmetic; SLT/SLTU return 0 or 1 zero-extended.
REQ-026 SUB/SLT/SLTU SHALL compute a_in + ~b_in + 1; C = carry-out (1 = no borrow); SLT = N^V; SLTU = !C.
REQ-027 Flags: ADD/SUB/SLT/SLTU output N, Z, C, V of the adder; AND/OR/XOR/MUL*/DIV*/REM* output N = result[XLEN-1], Z = (result == 0), C = V = 0; shifts and undefined opcodes output all flags 0.
REQ-028 DONE: result, flags, and op_err SHALL hold stable while out_valid && !out_ready; on out_valid && out_ready the block SHALL return to IDLE.
REQ-029 No new operation SHALL be accepted in the same cycle as the DONE-to-IDLE transition (no back-to-back bypass).
REQ-030 flush SHALL force IDLE on the next edge from any state, discard any pending result, and drop out_valid; flush has priority over accept and out_ready.
REQ-031 Inputs SHALL be sampled only at accept; changes to a_in, b_in, or alu_op during BUSY/DONE SHALL have no effect.

Reset
REQ-032 While rst_n is low: state = IDLE, out_valid = 0, result = 0, all flags = 0, op_err = 0, counter = 0; in_ready = 0 while rst_n is low.
REQ-033 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation with no out_valid pulse after release.
REQ-034 The first accept is possible on the first rising edge after rst_n deasserts.

Verification (XLEN=32)
REQ-035 SUB a=5, b=7 -> 1 cycle: result=0xFFFFFFFE, N=1, Z=0, C=0, V=0; SLTU same operands -> 1.
REQ-036 MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, result=0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-037 DIV a=-7, b=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=100, b=0 -> 0xFFFFFFFF after 1 cycle; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 1 cycle.
REQ-038 out_ready held low 10 cycles after out_valid -> result and flags stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 the cycle after.
REQ-039 flush at BUSY cycle 12 of DIVU, then ADD 1+1 -> no DIVU result appears; ADD result 2 with out_valid 1 cycle after its accept.
REQ-040 rst_n pulsed low mid-MUL -> all outputs 0 immediately; no out_valid after release; alu_op=10101 -> op_err=1, result=0.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential integer ALU: single-cycle arithmetic/logic/shift ops and
// iterative radix-2 multiply/divide behind a valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for an operation
//   BUSY  | one multiply or divide step per cycle
//   DONE  | result held until out_ready
module seq_alu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic [4:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            flag_z,
    output logic            flag_n,
    output logic            flag_c,
    output logic            flag_v,
    output logic            op_err
);
    localparam int SH_W = $clog2(XLEN);
    localparam int MSB  = XLEN - 1;

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB   = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4,  OP_SLT   = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7;
    localparam logic [4:0] OP_SRA  = 5'd8,  OP_SLTU  = 5'd9,  OP_MUL  = 5'd10, OP_MULHU = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd12, OP_DIVU  = 5'd13, OP_REM  = 5'd14, OP_REMU = 5'd15;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic             is_mul_q, is_mul_d, sel_q, sel_d, negq_q, negq_d, negr_q, negr_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;

    logic             accept, last_step;
    logic             is_sub, is_div, is_sdiv, div_zero, div_ovf, long_op, logic_fl;
    logic [XLEN-1:0]  b_eff, add_sum, imm_res, a_mag, b_mag;
    logic             add_c, add_v, lt_s, lt_u, imm_err;
    logic [3:0]       imm_flags;
    logic [SH_W-1:0]  shamt;
    logic [XLEN:0]    mul_sum, div_tmp, div_diff;
    logic [XLEN-1:0]  hi_n, lo_n, q_fin, r_fin, step_res;

    // Single-cycle datapath, also decides whether a divide can skip iteration.
    always_comb begin
        is_sub           = (alu_op == OP_SUB) || (alu_op == OP_SLT) || (alu_op == OP_SLTU);
        b_eff            = is_sub ? ~b_in : b_in;
        {add_c, add_sum} = {1'b0, a_in} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
        add_v            = (a_in[MSB] == b_eff[MSB]) && (add_sum[MSB] != a_in[MSB]);
        lt_s             = add_sum[MSB] ^ add_v;
        lt_u             = !add_c;
        shamt            = b_in[SH_W-1:0];
        is_div           = alu_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        is_sdiv          = (alu_op == OP_DIV) || (alu_op == OP_REM);
        div_zero         = (b_in == '0);
        div_ovf          = is_sdiv && (a_in == {1'b1, {(XLEN-1){1'b0}}}) && (b_in == '1);
        long_op          = (alu_op == OP_MUL) || (alu_op == OP_MULHU) || (is_div && !div_zero && !div_ovf);
        a_mag            = (is_sdiv && a_in[MSB]) ? -a_in : a_in;
        b_mag            = (is_sdiv && b_in[MSB]) ? -b_in : b_in;
        imm_res          = '0;
        imm_flags        = 4'b0000;
        imm_err          = 1'b0;
        logic_fl         = 1'b0;
        case (alu_op)
            OP_ADD, OP_SUB: begin
                imm_res   = add_sum;
                imm_flags = {add_sum[MSB], add_sum == '0, add_c, add_v};
            end
            OP_SLT: begin
                imm_res   = {{(XLEN-1){1'b0}}, lt_s};
                imm_flags = {add_sum[MSB], add_sum == '0, add_c, add_v};
            end
            OP_SLTU: begin
                imm_res   = {{(XLEN-1){1'b0}}, lt_u};
                imm_flags = {add_sum[MSB], add_sum == '0, add_c, add_v};
            end
            OP_AND:  begin imm_res = a_in & b_in; logic_fl = 1'b1; end
            OP_OR:   begin imm_res = a_in | b_in; logic_fl = 1'b1; end
            OP_XOR:  begin imm_res = a_in ^ b_in; logic_fl = 1'b1; end
            OP_SLL:  imm_res = a_in << shamt;
            OP_SRL:  imm_res = a_in >> shamt;
            OP_SRA:  imm_res = $signed(a_in) >>> shamt;
            OP_MUL, OP_MULHU: logic_fl = 1'b1;
            OP_DIV, OP_DIVU: begin imm_res = div_zero ? '1 : a_in; logic_fl = 1'b1; end
            OP_REM, OP_REMU: begin imm_res = div_zero ? a_in : '0; logic_fl = 1'b1; end
            default: imm_err = 1'b1;
        endcase
        if (logic_fl)
            imm_flags = {imm_res[MSB], imm_res == '0, 2'b00};
    end

    // One iteration: shift-add multiply or restoring divide on magnitudes.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_tmp  = {hi_q, lo_q[MSB]};
        div_diff = div_tmp - {1'b0, opnd_q};
        if (is_mul_q) begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[MSB:1]};
        end else if (!div_diff[XLEN]) begin
            hi_n = div_diff[MSB:0];
            lo_n = {lo_q[MSB-1:0], 1'b1};
        end else begin
            hi_n = div_tmp[MSB:0];
            lo_n = {lo_q[MSB-1:0], 1'b0};
        end
        q_fin = negq_q ? -lo_n : lo_n;
        r_fin = negr_q ? -hi_n : hi_n;
        if (is_mul_q) step_res = sel_q ? hi_n : lo_n;
        else          step_res = sel_q ? r_fin : q_fin;
    end

    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = long_op ? BUSY : DONE;
                BUSY:    if (last_step) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !flush && rst_n;
        out_valid = (state_q == DONE);
    end

    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        is_mul_d = is_mul_q;
        sel_d    = sel_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        if (accept) begin
            cnt_d    = '0;
            hi_d     = '0;
            is_mul_d = (alu_op == OP_MUL) || (alu_op == OP_MULHU);
            sel_d    = (alu_op == OP_MULHU) || (alu_op == OP_REM) || (alu_op == OP_REMU);
            lo_d     = is_mul_d ? b_in : a_mag;
            opnd_d   = is_mul_d ? a_in : b_mag;
            negq_d   = is_sdiv && (a_in[MSB] ^ b_in[MSB]);
            negr_d   = is_sdiv && a_in[MSB];
            if (!long_op) begin
                result_d = imm_res;
                flags_d  = imm_flags;
                err_d    = imm_err;
            end
        end else if ((state_q == BUSY) && !flush) begin
            cnt_d = cnt_q + CNT_W'(1);
            hi_d  = hi_n;
            lo_d  = lo_n;
            if (last_step) begin
                result_d = step_res;
                flags_d  = {step_res[MSB], step_res == '0, 2'b00};
                err_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_mul_q <= 1'b0;
            sel_q    <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= 4'b0000;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            is_mul_q <= is_mul_d;
            sel_q    <= sel_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];
    assign op_err = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
module tb_seq_alu;
    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a_in, b_in, result;
    logic [4:0]  alu_op;
    logic        flag_z, flag_n, flag_c, flag_v, op_err;

    seq_alu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .op_err(op_err)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    exp_t sb[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic seen = 1'b0;
    logic have_cur = 1'b0;
    logic rand_rdy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint unsigned ua, ub, p;
        longint sa, sbv, sum_s, dif_s;
        logic [31:0] d;
        logic [3:0] sub_fl;
        ua = a; ub = b; sa = $signed(a); sbv = $signed(b);
        p = ua * ub;
        sum_s = sa + sbv;
        dif_s = sa - sbv;
        d = a - b;
        sub_fl = {d[31], d == 32'd0, ua >= ub, (dif_s > SMAX) || (dif_s < SMIN)};
        e.res = 32'd0; e.fl = 4'd0; e.err = 1'b0; e.lat = 1; e.acc = 0;
        case (op)
            5'd0: begin
                e.res = a + b;
                e.fl = {e.res[31], e.res == 32'd0, ((ua + ub) >> 32) != 0, (sum_s > SMAX) || (sum_s < SMIN)};
            end
            5'd1:  begin e.res = d; e.fl = sub_fl; end
            5'd2:  e.res = a & b;
            5'd3:  e.res = a | b;
            5'd4:  e.res = a ^ b;
            5'd5:  begin e.res = (sa < sbv) ? 32'd1 : 32'd0; e.fl = sub_fl; end
            5'd6:  e.res = a << b[4:0];
            5'd7:  e.res = a >> b[4:0];
            5'd8:  e.res = $signed(a) >>> b[4:0];
            5'd9:  begin e.res = (ua < ub) ? 32'd1 : 32'd0; e.fl = sub_fl; end
            5'd10: begin e.res = p[31:0];  e.lat = 33; end
            5'd11: begin e.res = p[63:32]; e.lat = 33; end
            5'd12: e.res = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sbv);
            5'd13: e.res = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            5'd14: e.res = (b == 0) ? a : 32'(sa % sbv);
            5'd15: e.res = (b == 0) ? a : 32'(ua % ub);
            default: e.err = 1'b1;
        endcase
        if (op inside {5'd2, 5'd3, 5'd4, [5'd10:5'd15]})
            e.fl = {e.res[31], e.res == 32'd0, 2'b00};
        if ((op inside {5'd13, 5'd15}) && b != 0)
            e.lat = 33;
        if ((op inside {5'd12, 5'd14}) && b != 0 && !(a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            e.lat = 33;
        return e;
    endfunction

    // Called and returns just after a falling edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int g;
        g = 0;
        #1;
        while (!in_ready && g < 300) begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk); #1;
            g++;
        end
        if (!in_ready) begin
            chk("issue_timeout_in_ready", in_ready, 1);
            return;
        end
        in_valid = 1'b1; a_in = a; b_in = b; alu_op = op;
        @(posedge clk); #1;
        e = model(op, a, b);
        e.acc = cyc;
        sb.push_back(e);
        in_valid = 1'b0; a_in = $urandom; b_in = $urandom; alu_op = 5'($urandom);
        @(negedge clk);
    endtask

    task automatic drain();
        int g;
        g = 0;
        #1;
        while ((sb.size() != 0 || !in_ready) && g < 200) begin
            @(negedge clk); #1;
            g++;
        end
        chk("drain_done", {31'd0, sb.size() == 0 && in_ready}, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    chk("result", result, cur.res);
                    chk("flags_nzcv", {flag_n, flag_z, flag_c, flag_v}, cur.fl);
                    chk("op_err", op_err, cur.err);
                    chk("latency", cyc - cur.acc + 1, cur.lat);
                end
            end else if (have_cur) begin
                chk("hold_stable", {op_err, flag_n, flag_z, flag_c, flag_v, result},
                    {cur.err, cur.fl, cur.res});
            end
        end else begin
            seen = 1'b0;
            have_cur = 1'b0;
        end
    end

    initial begin
        logic [31:0] sp [5];
        logic [4:0]  op;
        logic [31:0] ra, rb;
        int          k, g;
        sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; alu_op = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_n, flag_z, flag_c, flag_v, op_err}, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;

        issue(5'd1, 32'd5, 32'd7);
        issue(5'd9, 32'd5, 32'd7);
        issue(5'd0, 32'h7FFF_FFFF, 32'd1);
        issue(5'd5, 32'h8000_0000, 32'd1);
        issue(5'd8, 32'h8000_00F0, 32'd36);
        issue(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(5'd12, -32'sd7, 32'd2);
        issue(5'd14, -32'sd7, 32'd2);
        issue(5'd13, 32'd100, 32'd0);
        issue(5'd12, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'd20, 32'd3, 32'd4);
        drain();

        // Consumer stalls for ten cycles with the result parked.
        out_ready = 1'b0;
        issue(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        g = 0;
        #1;
        while (!out_valid && g < 60) begin @(negedge clk); #1; g++; end
        chk("stall_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);

        // Flush during a divide, then a short op.
        issue(5'd13, 32'd1000, 32'd7);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_blocks_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        issue(5'd0, 32'd1, 32'd1);
        repeat (40) @(negedge clk);
        drain();

        // Reset asserted in the middle of a multiply.
        issue(5'd0, 32'd3, 32'd4);
        drain();
        issue(5'd10, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {flag_n, flag_z, flag_c, flag_v, op_err}, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        issue(5'b10101, 32'hDEAD_BEEF, 32'h1);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            k  = $urandom_range(0, 17);
            op = (k < 16) ? 5'(k) : 5'($urandom_range(16, 31));
            ra = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
            issue(op, ra, rb);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
